// File: rtl/elec_chain_ctrl_if.sv
// Command/response bus between the SPI command decoder (master) and the
// electrode-MUX chain sequencer (slave).
interface elec_chain_ctrl_if #(
  parameter int GROUP_WID = 16
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [5:0]           cmd_code;
  logic [9:0]           cmd_addr;
  logic [GROUP_WID-1:0] cmd_data;
  logic                 rsp_valid;
  logic [GROUP_WID-1:0] rsp_data;
  logic                 busy;

  modport master (
    output cmd_valid, cmd_code, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/elec_chain_ctrl.sv
// Electrode-MUX scan-chain sequencer: caches a CHAIN_LEN-bit image and shifts it
// into the probe chain, reads one group back by recirculation, or pulses chain reset.
module elec_chain_ctrl #(
  parameter int CHAIN_LEN = 1024,
  parameter int GROUP_WID = 16,
  parameter int DIV       = 12,
  parameter int RST_PER   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  elec_chain_ctrl_if.slave        bus,
  output logic                    chain_clk,
  output logic                    chain_data,
  input  logic                    chain_q,
  output logic                    chain_rst_n
);

  localparam logic [5:0] CODE_WR    = 6'd10;
  localparam logic [5:0] CODE_RD    = 6'd11;
  localparam logic [5:0] CODE_RST   = 6'd12;
  localparam logic [5:0] CODE_CACHE = 6'd23;

  localparam int N_WORDS = CHAIN_LEN / GROUP_WID;
  localparam int B_W     = $clog2(CHAIN_LEN);
  localparam int G_W     = $clog2(GROUP_WID);
  localparam int A_W     = B_W - G_W;
  localparam int PH_W    = $clog2(DIV);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_WR,
    SHIFT_RD,
    RESP,
    CHAIN_RST
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [PH_W-1:0]      ph;
  logic [PH_W-1:0]      ph_nxt;
  logic [B_W-1:0]       b;
  logic [B_W-1:0]       b_nxt;
  logic [A_W-1:0]       grp;
  logic [GROUP_WID-1:0] cache [N_WORDS];
  logic [GROUP_WID-1:0] rsp_shift;
  logic [GROUP_WID-1:0] rsp_data_q;
  logic                 accept;
  logic                 cache_we;
  logic                 last_bit;
  logic                 last_rst;
  logic                 shifting_nxt;
  logic [B_W-1:0]       img_idx_cur;
  logic [B_W-1:0]       img_idx_nxt;
  logic                 unused_addr_hi;

  assign accept       = bus.cmd_valid && (state == IDLE);
  assign last_bit     = (b == B_W'(CHAIN_LEN - 1)) && (ph == PH_W'(DIV - 1));
  assign last_rst     = (b == B_W'(RST_PER - 1)) && (ph == PH_W'(DIV - 1));
  assign shifting_nxt = (state_nxt == SHIFT_WR) || (state_nxt == SHIFT_RD);
  // The chain is loaded MSB-first, so shift period b carries image bit CHAIN_LEN-1-b.
  assign img_idx_cur  = B_W'(CHAIN_LEN - 1) - b;
  assign img_idx_nxt  = B_W'(CHAIN_LEN - 1) - b_nxt;
  assign bus.rsp_data = rsp_data_q;
  assign unused_addr_hi = ^bus.cmd_addr[9:A_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.cmd_code)
            CODE_WR:  state_nxt = SHIFT_WR;
            CODE_RD:  state_nxt = SHIFT_RD;
            CODE_RST: state_nxt = CHAIN_RST;
            default:  state_nxt = IDLE;
          endcase
        end
      end
      SHIFT_WR:  if (last_bit) state_nxt = IDLE;
      SHIFT_RD:  if (last_bit) state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      CHAIN_RST: if (last_rst) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Counters restart from zero on every state entry; CHAIN_RST reuses b to count chain periods.
  always_comb begin
    ph_nxt = '0;
    b_nxt  = '0;
    if ((state == SHIFT_WR || state == SHIFT_RD || state == CHAIN_RST) && (state_nxt == state)) begin
      if (ph == PH_W'(DIV - 1)) begin
        b_nxt = b + B_W'(1);
      end else begin
        ph_nxt = ph + PH_W'(1);
        b_nxt  = b;
      end
    end
  end

  always_comb begin
    bus.cmd_ready = (state == IDLE);
    bus.busy      = (state != IDLE);
    bus.rsp_valid = (state == RESP);
    chain_rst_n   = ~rst & (state != CHAIN_RST);
    cache_we      = accept && (bus.cmd_code == CODE_CACHE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_WORDS; i++) begin
        cache[i] <= '0;
      end
    end else if (cache_we) begin
      cache[bus.cmd_addr[A_W-1:0]] <= bus.cmd_data;
    end
  end

  // chain_clk and chain_data are computed from next-cycle counters so both leave a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph         <= '0;
      b          <= '0;
      grp        <= '0;
      rsp_shift  <= '0;
      rsp_data_q <= '0;
      chain_clk  <= 1'b0;
      chain_data <= 1'b0;
    end else begin
      ph        <= ph_nxt;
      b         <= b_nxt;
      chain_clk <= shifting_nxt && (ph_nxt >= PH_W'(DIV / 2));
      if (ph_nxt == '0) begin
        if (state_nxt == SHIFT_WR) begin
          chain_data <= cache[img_idx_nxt[B_W-1:G_W]][img_idx_nxt[G_W-1:0]];
        end else if (state_nxt == SHIFT_RD) begin
          chain_data <= chain_q;
        end
      end
      if (accept && bus.cmd_code == CODE_RD) begin
        grp       <= bus.cmd_addr[A_W-1:0];
        rsp_shift <= '0;
      end
      // chain_q still shows the bit about to be shifted out, just before the capture edge.
      if (state == SHIFT_RD && ph == PH_W'(DIV / 2 - 1) && img_idx_cur[B_W-1:G_W] == grp) begin
        rsp_shift <= {rsp_shift[GROUP_WID-2:0], chain_q};
      end
      if (state == SHIFT_RD && state_nxt == RESP) begin
        rsp_data_q <= rsp_shift;
      end
    end
  end

endmodule

// File: tb/tb_elec_chain_ctrl.sv
// Bench for elec_chain_ctrl: drives commands, models the probe scan chain and
// scoreboards chain words and read responses.
module tb_elec_chain_ctrl;
  localparam int CHAIN_LEN = 1024;
  localparam int GROUP_WID = 16;
  localparam int DIV       = 12;
  localparam int RST_PER   = 4;
  localparam int SHIFT_CYC = CHAIN_LEN * DIV;
  localparam int N_WORDS   = CHAIN_LEN / GROUP_WID;
  localparam logic [5:0] CODE_WR    = 6'd10;
  localparam logic [5:0] CODE_RD    = 6'd11;
  localparam logic [5:0] CODE_RST   = 6'd12;
  localparam logic [5:0] CODE_CACHE = 6'd23;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chain_clk;
  logic chain_data;
  logic chain_q;
  logic chain_rst_n;

  elec_chain_ctrl_if #(.GROUP_WID(GROUP_WID)) bus ();

  elec_chain_ctrl #(
    .CHAIN_LEN(CHAIN_LEN),
    .GROUP_WID(GROUP_WID),
    .DIV(DIV),
    .RST_PER(RST_PER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .chain_clk(chain_clk),
    .chain_data(chain_data),
    .chain_q(chain_q),
    .chain_rst_n(chain_rst_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] img [N_WORDS];
  logic [15:0] exp_word_q [$];
  logic [15:0] exp_rsp_q [$];
  logic [CHAIN_LEN-1:0] chain_m = '0;
  logic wr_mon = 1'b0;
  int chain_edges = 0;
  int bit_cnt = 0;
  logic [15:0] word_acc = '0;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Probe chain: stage 0 takes chain_data, chain_q is the last stage, cleared by chain_rst_n.
  always @(posedge chain_clk or negedge chain_rst_n) begin
    if (!chain_rst_n) chain_m <= '0;
    else              chain_m <= {chain_m[CHAIN_LEN-2:0], chain_data};
  end
  assign chain_q = chain_m[CHAIN_LEN-1];

  always @(posedge chain_clk) begin
    chain_edges++;
    if (wr_mon) begin
      word_acc = {word_acc[14:0], chain_data};
      bit_cnt++;
      if (bit_cnt == 16) begin
        bit_cnt = 0;
        if (exp_word_q.size() > 0) check_output("wr_chain_word", word_acc, exp_word_q.pop_front());
      end
    end else begin
      bit_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (exp_rsp_q.size() == 0) check_output("rsp_unexpected", bus.rsp_valid, 1'b0);
      else                       check_output("rsp_data", bus.rsp_data, exp_rsp_q.pop_front());
    end
  end

  task automatic apply_stimulus(input logic [5:0] code, input logic [9:0] addr,
                                input logic [15:0] data, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = code;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    while (!bus.cmd_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) check_output("accept_timeout", bus.cmd_ready, 1'b1);
    @(posedge clk);
    if (!hold) begin
      #1 bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 20000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_write(input bit hold_next, output int busy_n, output int edges);
    int e_start;
    for (int w = N_WORDS - 1; w >= 0; w--) exp_word_q.push_back(img[w]);
    e_start = chain_edges;
    wr_mon = 1'b1;
    apply_stimulus(CODE_WR, 10'd0, 16'd0, hold_next);
    count_busy(busy_n);
    wr_mon = 1'b0;
    edges = chain_edges - e_start;
  endtask

  task automatic do_read(input logic [9:0] addr);
    int n;
    int g;
    logic [15:0] expected;
    g = int'(addr[5:0]);
    expected = chain_m[g*16 +: 16];
    exp_rsp_q.push_back(expected);
    apply_stimulus(CODE_RD, addr, 16'd0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 13000);
    check_output("rd_latency", n, SHIFT_CYC + 1);
    @(negedge clk);
    check_output("rsp_valid_pulse", bus.rsp_valid, 1'b0);
    check_output("rsp_data_hold", bus.rsp_data, expected);
    check_output("rd_idle_after", bus.cmd_ready, 1'b1);
  endtask

  initial begin
    int n;
    int e0;
    int lo;
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = '0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    for (int i = 0; i < N_WORDS; i++) img[i] = '0;

    repeat (3) @(negedge clk);
    check_output("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check_output("rst_busy", bus.busy, 1'b0);
    check_output("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_output("rst_rsp_data", bus.rsp_data, 16'h0);
    check_output("rst_chain_clk", chain_clk, 1'b0);
    check_output("rst_chain_data", chain_data, 1'b0);
    check_output("rst_chain_rst_n", chain_rst_n, 1'b0);
    rst = 1'b0;
    #1;
    check_output("release_chain_rst_n", chain_rst_n, 1'b1);

    $display("[TB] cache load and WRITE");
    apply_stimulus(CODE_CACHE, 10'd63, 16'h8001, 1'b0);
    img[63] = 16'h8001;
    @(negedge clk);
    check_output("cache_wr_no_busy", bus.busy, 1'b0);
    apply_stimulus(CODE_CACHE, 10'd0, 16'hA5C3, 1'b0);
    img[0] = 16'hA5C3;
    run_write(1'b0, n, e0);
    check_output("wr_busy_cycles", n, SHIFT_CYC);
    check_output("wr_chain_edges", e0, CHAIN_LEN);
    check_output("wr_words_left", exp_word_q.size(), 0);
    check_output("wr_cmd_ready", bus.cmd_ready, 1'b1);
    check_output("wr_chain_grp0", chain_m[15:0], img[0]);
    check_output("wr_chain_grp63", chain_m[CHAIN_LEN-1 -: 16], img[63]);

    $display("[TB] READ groups 0 and 63");
    do_read(10'd0);
    do_read(10'd63);

    $display("[TB] chain RESET");
    apply_stimulus(CODE_RST, 10'd0, 16'd0, 1'b0);
    lo = 0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!chain_rst_n) lo++;
      if (!chain_rst_n && bus.busy) n++;
    end
    check_output("rst_low_cycles", lo, RST_PER * DIV);
    check_output("rst_busy_cycles", n, RST_PER * DIV);
    do_read(10'd0);

    $display("[TB] abort READ at b=500");
    apply_stimulus(CODE_RD, 10'd0, 16'd0, 1'b0);
    repeat (500 * DIV + 9) @(negedge clk);
    check_output("abort_pre_chain_clk", chain_clk, 1'b1);
    check_output("abort_pre_busy", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    check_output("abort_chain_clk", chain_clk, 1'b0);
    check_output("abort_chain_rst_n", chain_rst_n, 1'b0);
    check_output("abort_cmd_ready", bus.cmd_ready, 1'b1);
    check_output("abort_busy", bus.busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_output("abort_idle", bus.cmd_ready, 1'b1);

    $display("[TB] unknown code and high address bits");
    e0 = chain_edges;
    apply_stimulus(6'd5, 10'd0, 16'hFFFF, 1'b0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
    end
    check_output("code5_busy", n, 0);
    check_output("code5_chain_edges", chain_edges - e0, 0);
    for (int i = 0; i < N_WORDS; i++) img[i] = '0;
    apply_stimulus(CODE_CACHE, 10'h3C5, 16'h5A5A, 1'b0);
    img[5] = 16'h5A5A;

    $display("[TB] WRITE with a held WRITE behind it");
    bus.cmd_valid = 1'b0;
    run_write(1'b1, n, e0);
    check_output("wr2_busy_cycles", n, SHIFT_CYC);
    check_output("wr2_chain_edges", e0, CHAIN_LEN);
    check_output("wr2_words_left", exp_word_q.size(), 0);
    check_output("held_ready", bus.cmd_ready, 1'b1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    check_output("held_wr_accepted", bus.busy, 1'b1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog abort");
  end

endmodule

// File: doc/elec_chain_ctrl.md
# elec_chain_ctrl

Sequencer for the probe electrode-MUX configuration scan chain. It accepts decoded SPI bus commands (code/addr/data) and holds a 1024-bit configuration image in a 64×16 cache. On command it serially shifts the image into the chain, reads one 16-bit group back non-destructively, or pulses the chain reset. It sits between the SPI command decoder and the probe pads and runs entirely on the 38.4 MHz chip clock, generating the ~3.2 MHz chain clock internally.

## Interface
- CHAIN_LEN, 1024, scan-chain length in bits (multiple of GROUP_WID).
- GROUP_WID, 16, bits per cache word and per read group.
- DIV, 12, clk cycles per chain-clock period (even, ≥4).
- RST_PER, 4, chain-clock periods that chain_rst_n is held low by RESET.
- Command codes (decided): CODE_WR=10, CODE_RD=11, CODE_RST=12, CODE_CACHE=23.
---
- clk  in  1  chip clock, 38.4 MHz; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present on cmd_code/cmd_addr/cmd_data.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
- cmd_code  in  6  command code.
- cmd_addr  in  10  bits [5:0] are the word/group index; bits [9:6] are ignored.
- cmd_data  in  16  cache write data.
- rsp_valid  out  1  one-cycle pulse when read data is ready.
- rsp_data  out  16  read group; held until the next READ completes.
- busy  out  1  high whenever not in IDLE.
- chain_clk  out  1  scan-chain clock to the probe.
- chain_data  out  1  serial data into chain stage 0.
- chain_q  in  1  serial output of the last chain stage.
- chain_rst_n  out  1  active-low chain reset to the probe.

## Operation
- Bit numbering: image bit k = cache[k/16][k%16]. The chain shifts MSB-first, so image bit CHAIN_LEN-1 enters first. After a full WRITE, chain stage j holds image bit j. chain_q presents stage CHAIN_LEN-1.
- States: IDLE, SHIFT_WR, SHIFT_RD, RESP, CHAIN_RST.
- IDLE: on accept:
  - CODE_CACHE writes cache[cmd_addr[5:0]] <= cmd_data and stays in IDLE (single cycle, no busy).
  - CODE_WR goes to SHIFT_WR. CODE_RD latches grp=cmd_addr[5:0] and goes to SHIFT_RD. CODE_RST goes to CHAIN_RST.
  - Any other code is accepted and ignored.
- Shift states use a phase counter ph (0..DIV-1) and a bit counter b (0..CHAIN_LEN-1). Both are cleared on entry.
  - b increments when ph==DIV-1. Leave the state when b==CHAIN_LEN-1 and ph==DIV-1.
  - chain_clk = (ph ≥ DIV/2) while shifting, else 0. The chain captures on the rising edge at ph==DIV/2.
  - chain_data changes only at ph==0 and is held for the whole period.
- SHIFT_WR: chain_data = image bit (CHAIN_LEN-1-b). Exit to IDLE.
- SHIFT_RD: recirculate: chain_data = chain_q, sampled at ph==0, so the chain contents are unchanged after CHAIN_LEN shifts.
  - At ph==DIV/2-1, if (CHAIN_LEN-1-b)/16 == grp, shift rsp_shift <= {rsp_shift[14:0], chain_q}.
  - Exit to RESP.
- RESP: rsp_data <= rsp_shift, rsp_valid=1 for exactly one cycle, then IDLE.
- CHAIN_RST: chain_rst_n=0 for RST_PER*DIV cycles, then IDLE. The cache is not modified.
- The cache is never altered by WRITE, READ or RESET commands.

## Timing
- Reset values:
  - Outputs: cmd_ready=1 (IDLE), busy=0, rsp_valid=0, rsp_data=0, chain_clk=0, chain_data=0, chain_rst_n=0 while rst is high and 1 after.
  - Internal: cache all 0, ph=b=0.
- rst asserted mid-operation aborts immediately: state goes to IDLE and chain_clk drops at once. No rsp_valid is produced for the aborted read.
- WRITE: CHAIN_LEN*DIV cycles busy (12288 at defaults), then cmd_ready is high on the next cycle.
- READ: CHAIN_LEN*DIV cycles shifting plus 1 RESP cycle. rsp_valid rises CHAIN_LEN*DIV+1 cycles after accept.
- RESET: busy for RST_PER*DIV cycles (48 at defaults).
- Commands are never queued. While busy, cmd_ready=0 and upstream holds its command.
- CODE_CACHE during busy is not accepted. A cache write followed immediately by CODE_WR uses the new word.
- chain_clk is glitch-free: it is a registered output.

## Test plan
- Cache writes: word 63=0x8001, word 0=0xA5C3, others 0; then CODE_WR. Required:
  - First chain_data bit 1, next 14 bits 0, then 1, then zeros.
  - The last 16 bits, MSB-first, are 0xA5C3.
  - Exactly 1024 chain_clk rising edges; cmd_ready returns after 12288 cycles.
- Following that WRITE, with a 1024-bit shift-register chain model: CODE_RD addr=0 gives rsp_data=0xA5C3 and rsp_valid at accept+12289. A second CODE_RD addr=63 gives 0x8001 (chain was preserved).
- CODE_RST: chain_rst_n is low for exactly 48 cycles, busy is high meanwhile, and a subsequent CODE_RD addr=0 still returns the chain-model value.
- Mid-shift abort: assert rst at b=500 during SHIFT_RD. Required: chain_clk=0 and chain_rst_n=0 immediately, no rsp_valid, IDLE with cache=0 after release.
- Command handling:
  - cmd_valid held with CODE_WR during an active WRITE is accepted only after completion.
  - cmd_code=5 is accepted with no busy and no chain activity.
  - CODE_CACHE with addr=0x3C5 writes word 5.
